rggen_bit_field_event_counter: RTL and testbench

// - Hardware event-counter bit field; consumes the bit_field modport of rggen_bit_field_if, directly downstream of the register.
// - Counts hardware events with a per-cycle step, supports masked software writes and optional clear-on-read.
// - Wrap or saturate at full scale, with a sticky overflow flag for the interrupt logic of the register block.

---
 rtl/rggen_event_counter_pkg.sv | 38 +++
 rtl/rggen_bit_field_if.sv | 20 ++
 rtl/rggen_counter_incrementer.sv | 22 ++
 rtl/rggen_bit_field_event_counter.sv | 103 ++++++++++
 tb/tb_rggen_bit_field_event_counter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/rggen_event_counter_pkg.sv
// Shared types and helpers for hardware event-counter bit fields.
// Holds the per-cycle update selector and a generic width-parameterised add.
package rggen_event_counter_pkg;

  localparam int unsigned CNT_MAX_WIDTH = 64;

  typedef logic [CNT_MAX_WIDTH-1:0] cnt_word_t;

  typedef enum logic [2:0] {
    CNT_HOLD,
    CNT_CLEAR,
    CNT_WRITE,
    CNT_RC,
    CNT_INC
  } rggen_counter_update_e;

  // Returns {carry, result}; operands must already fit in 'width' bits.
  function automatic logic [CNT_MAX_WIDTH:0] saturating_add(
    input cnt_word_t   x,
    input cnt_word_t   step,
    input int unsigned width,
    input logic        saturate
  );
    logic [CNT_MAX_WIDTH:0] sum;
    cnt_word_t              ones;
    cnt_word_t              result;
    logic                   carry;
    sum    = {1'b0, x} + {1'b0, step};
    ones   = {CNT_MAX_WIDTH{1'b1}} >> (CNT_MAX_WIDTH - width);
    carry  = (sum >> width) != '0;
    result = sum[CNT_MAX_WIDTH-1:0] & ones;
    if (carry && saturate) begin
      result = ones;
    end
    return {carry, result};
  endfunction

endpackage

// File: rtl/rggen_bit_field_if.sv
// Register-to-bit-field handshake: access strobes and data in, field value out.
interface rggen_bit_field_if #(
  parameter int WIDTH = 32
);
  logic             write_valid;
  logic             read_valid;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] read_data;
  logic [WIDTH-1:0] value;

  modport bit_field (
    input  write_valid,
    input  read_valid,
    input  mask,
    input  write_data,
    output read_data,
    output value
  );
endinterface

// File: rtl/rggen_counter_incrementer.sv
// Combinational counter step: WIDTH+1 add with saturate-or-wrap at full scale.
// Overflow reports the carry out in both modes.
module rggen_counter_incrementer
  import rggen_event_counter_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int STEP_WIDTH = 4,
  parameter bit SATURATE   = 1'b1
) (
  input  logic [WIDTH-1:0]      value,
  input  logic [STEP_WIDTH-1:0] step,
  output logic [WIDTH-1:0]      result,
  output logic                  overflow
);

  logic [WIDTH:0] sum;

  assign sum      = {1'b0, value} + (WIDTH+1)'(step);
  assign overflow = sum[WIDTH];
  assign result   = (sum[WIDTH] && SATURATE) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];

endmodule

// File: rtl/rggen_bit_field_event_counter.sv
// Hardware event counter bit field with masked SW writes, optional clear-on-read,
// saturate/wrap at full scale and a sticky overflow flag.
module rggen_bit_field_event_counter
  import rggen_event_counter_pkg::*;
#(
  parameter int               WIDTH         = 16,
  parameter int               STEP_WIDTH    = 4,
  parameter logic [WIDTH-1:0] INITIAL_VALUE = '0,
  parameter bit               SATURATE      = 1'b1,
  parameter bit               CLEAR_ON_READ = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  rggen_bit_field_if.bit_field  bit_field_if,
  input  logic                  i_count_en,
  input  logic [STEP_WIDTH-1:0] i_step,
  input  logic                  i_clear,
  output logic                  o_overflow,
  output logic [WIDTH-1:0]      o_count
);

  rggen_counter_update_e update;
  logic [WIDTH-1:0]      counter_reg;
  logic [WIDTH-1:0]      counter_next;
  logic                  overflow_reg;
  logic                  overflow_next;
  logic [WIDTH-1:0]      inc_base;
  logic [WIDTH-1:0]      inc_result;
  logic                  inc_overflow;

  always_comb begin
    update = CNT_HOLD;
    if (i_clear) begin
      update = CNT_CLEAR;
    end else if (bit_field_if.write_valid) begin
      update = CNT_WRITE;
    end else if (bit_field_if.read_valid && CLEAR_ON_READ) begin
      update = CNT_RC;
    end else if (i_count_en) begin
      update = CNT_INC;
    end
  end

  // Clear-on-read restarts counting from zero so a same-cycle event still counts.
  assign inc_base = (update == CNT_RC) ? '0 : counter_reg;

  rggen_counter_incrementer #(
    .WIDTH      (WIDTH),
    .STEP_WIDTH (STEP_WIDTH),
    .SATURATE   (SATURATE)
  ) u_incrementer (
    .value    (inc_base),
    .step     (i_step),
    .result   (inc_result),
    .overflow (inc_overflow)
  );

  always_comb begin
    counter_next  = counter_reg;
    overflow_next = overflow_reg;
    case (update)
      CNT_CLEAR: begin
        counter_next  = INITIAL_VALUE;
        overflow_next = 1'b0;
      end
      CNT_WRITE: begin
        counter_next = (counter_reg & ~bit_field_if.mask) |
                       (bit_field_if.write_data & bit_field_if.mask);
        if (bit_field_if.mask != '0) begin
          overflow_next = 1'b0;
        end
      end
      CNT_RC: begin
        counter_next  = i_count_en ? inc_result : '0;
        overflow_next = i_count_en & inc_overflow;
      end
      CNT_INC: begin
        counter_next  = inc_result;
        overflow_next = overflow_reg | inc_overflow;
      end
      default: begin
        counter_next  = counter_reg;
        overflow_next = overflow_reg;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      counter_reg  <= INITIAL_VALUE;
      overflow_reg <= 1'b0;
    end else begin
      counter_reg  <= counter_next;
      overflow_reg <= overflow_next;
    end
  end

  assign bit_field_if.read_data = counter_reg;
  assign bit_field_if.value     = counter_reg;
  assign o_count                = counter_reg;
  assign o_overflow             = overflow_reg;

endmodule

// File: tb/tb_rggen_bit_field_event_counter.sv
// Bench for the event counter: three configurations driven by one stimulus stream,
// an arithmetic reference model checked every cycle, plus hand-computed expectations.
module tb_rggen_bit_field_event_counter;

  localparam int       N = 3;
  // index 0: defaults, 1: wrap, 2: saturate + clear-on-read
  localparam logic [2:0] SAT_P = 3'b101;
  localparam logic [2:0] COR_P = 3'b100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        count_en = 1'b0;
  logic [3:0]  step = '0;
  logic        clear = 1'b0;
  logic        write_valid = 1'b0;
  logic        read_valid = 1'b0;
  logic [15:0] mask = '0;
  logic [15:0] write_data = '0;

  logic [15:0] cnt_o [N];
  logic [15:0] rd_o  [N];
  logic [15:0] val_o [N];
  logic        ovf_o [N];

  logic [16:0] m_st [N];   // {overflow, count}

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_dut
      rggen_bit_field_if #(.WIDTH(16)) bf_if ();
      assign bf_if.write_valid = write_valid;
      assign bf_if.read_valid  = read_valid;
      assign bf_if.mask        = mask;
      assign bf_if.write_data  = write_data;

      rggen_bit_field_event_counter #(
        .WIDTH         (16),
        .STEP_WIDTH    (4),
        .INITIAL_VALUE (16'h0000),
        .SATURATE      (SAT_P[gi]),
        .CLEAR_ON_READ (COR_P[gi])
      ) u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .bit_field_if (bf_if),
        .i_count_en   (count_en),
        .i_step       (step),
        .i_clear      (clear),
        .o_overflow   (ovf_o[gi]),
        .o_count      (cnt_o[gi])
      );

      assign rd_o[gi]  = bf_if.read_data;
      assign val_o[gi] = bf_if.value;
    end
  endgenerate

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Next state from the priority rules, using plain integer arithmetic.
  function automatic logic [16:0] model_next(input int k, input logic [16:0] st);
    int   c;
    int   s;
    logic o;
    c = int'(st[15:0]);
    o = st[16];
    if (clear) return 17'h0;
    if (write_valid) begin
      c = (c & ~int'(mask)) | (int'(write_data) & int'(mask));
      if (mask != 16'h0) o = 1'b0;
      return {o, c[15:0]};
    end
    if (read_valid && COR_P[k]) begin
      s = count_en ? int'(step) : 0;
      o = 1'b0;
    end else if (count_en) begin
      s = c + int'(step);
    end else begin
      return st;
    end
    if (s > 65535) begin
      o = 1'b1;
      s = SAT_P[k] ? 65535 : s - 65536;
    end
    return {o, s[15:0]};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) m_st[k] <= 17'h0;
    end else begin
      for (int k = 0; k < N; k++) m_st[k] <= model_next(k, m_st[k]);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        check($sformatf("dut%0d o_count", k),   {16'h0, cnt_o[k]}, {16'h0, m_st[k][15:0]});
        check($sformatf("dut%0d read_data", k), {16'h0, rd_o[k]},  {16'h0, m_st[k][15:0]});
        check($sformatf("dut%0d value", k),     {16'h0, val_o[k]}, {16'h0, m_st[k][15:0]});
        check($sformatf("dut%0d overflow", k),  {31'h0, ovf_o[k]}, {31'h0, m_st[k][16]});
      end
    end
  end

  task automatic drive(input logic en, input logic [3:0] st, input logic clr,
                       input logic wv, input logic rv,
                       input logic [15:0] msk, input logic [15:0] wd);
    @(posedge clk);
    #1;
    count_en    = en;
    step        = st;
    clear       = clr;
    write_valid = wv;
    read_valid  = rv;
    mask        = msk;
    write_data  = wd;
    $display("t=%0t en=%0b step=%0d clr=%0b wv=%0b rv=%0b mask=%h wd=%h | cnt=%h/%h/%h ovf=%0b%0b%0b",
             $time, en, st, clr, wv, rv, msk, wd,
             cnt_o[0], cnt_o[1], cnt_o[2], ovf_o[0], ovf_o[1], ovf_o[2]);
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < N; k++) begin
      check("reset count", {16'h0, cnt_o[k]}, 32'h0);
      check("reset overflow", {31'h0, ovf_o[k]}, 32'h0);
    end

    repeat (5) drive(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    idle();
    check("five events count", {16'h0, cnt_o[0]}, 32'h5);
    check("five events read_data", {16'h0, rd_o[0]}, 32'h5);
    check("five events overflow", {31'h0, ovf_o[0]}, 32'h0);

    drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'hFFFE);
    drive(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    idle();
    check("saturate count", {16'h0, cnt_o[0]}, 32'hFFFF);
    check("saturate overflow", {31'h0, ovf_o[0]}, 32'h1);
    check("wrap count", {16'h0, cnt_o[1]}, 32'h0001);
    check("wrap overflow", {31'h0, ovf_o[1]}, 32'h1);

    drive(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    idle();
    check("saturate hold count", {16'h0, cnt_o[0]}, 32'hFFFF);
    check("saturate hold overflow", {31'h0, ovf_o[0]}, 32'h1);

    drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 16'h00FF, 16'h0042);
    idle();
    check("masked write count", {16'h0, cnt_o[1]}, 32'h0042);
    check("masked write overflow", {31'h0, ovf_o[1]}, 32'h0);
    check("masked write sat count", {16'h0, cnt_o[0]}, 32'hFF42);

    drive(1'b1, 4'd5, 1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h1234);
    idle();
    for (int k = 0; k < N; k++) check("clear wins", {16'h0, cnt_o[k]}, 32'h0);

    drive(1'b1, 4'd2, 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0010);
    idle();
    check("write drops increment", {16'h0, cnt_o[0]}, 32'h0010);

    drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0007);
    drive(1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    check("clear-on-read read_data", {16'h0, rd_o[2]}, 32'h7);
    idle();
    check("clear-on-read keeps event", {16'h0, cnt_o[2]}, 32'h2);
    check("plain read counts", {16'h0, cnt_o[0]}, 32'h9);

    drive(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    idle();
    check("zero step count", {16'h0, cnt_o[0]}, 32'h9);
    check("zero step overflow", {31'h0, ovf_o[0]}, 32'h0);

    drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF);
    drive(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h1234);
    idle();
    check("zero-mask write sat count", {16'h0, cnt_o[0]}, 32'hFFFF);
    check("zero-mask write keeps overflow", {31'h0, ovf_o[0]}, 32'h1);
    check("zero-mask write wrap count", {16'h0, cnt_o[1]}, 32'h0004);

    drive(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < N; k++) begin
      check("async reset count", {16'h0, cnt_o[k]}, 32'h0);
      check("async reset overflow", {31'h0, ovf_o[k]}, 32'h0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    check("after reset release", {16'h0, cnt_o[0]}, 32'h0);

    for (int i = 0; i < 200; i++) begin
      logic        r_wv;
      logic        r_rv;
      logic [15:0] r_wd;
      r_wv = ($urandom_range(0, 7) == 0);
      r_rv = !r_wv && ($urandom_range(0, 3) == 0);
      r_wd = ($urandom_range(0, 1) == 1) ? {12'hFFF, 4'($urandom_range(0, 15))}
                                         : 16'($urandom);
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 19) == 0), r_wv, r_rv,
            ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'($urandom), r_wd);
    end
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
